// File: rtl/fwrisc_trace_aligner.sv
// fwrisc_trace_aligner
// Realigns register-write and data-bus events from a pipelined core with the
// retire pulse of the instruction that owns them, so a tracer sees a single
// coherent event per retired instruction.
//
// Handshake: a data-bus transfer completes in the cycle where dvalid && dready
// are both 1; dvalid without dready (or dready without dvalid) is not a
// transfer. The register-file write port is a plain strobe (rf_we). The
// i_retire input is a one-cycle pulse with no back-pressure; the outputs
// ivalid/mvalid/rd_write are one-cycle pulses and nothing downstream can stall.
module fwrisc_trace_aligner #(
    parameter bit TRACE_LOADS = 1'b0,
    parameter bit DROP_X0     = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    input  logic        i_retire,
    input  logic [5:0]  i_ra_raddr,
    input  logic [5:0]  i_rb_raddr,
    input  logic [31:0] i_ra_rdata,
    input  logic [31:0] i_rb_rdata,
    input  logic [5:0]  rf_waddr,
    input  logic [31:0] rf_wdata,
    input  logic        rf_we,
    input  logic        dvalid,
    input  logic        dready,
    input  logic        dwrite,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    input  logic [31:0] drdata,
    input  logic [3:0]  dwstb,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        ivalid,
    output logic [5:0]  ra_raddr,
    output logic [5:0]  rb_raddr,
    output logic [31:0] ra_rdata,
    output logic [31:0] rb_rdata,
    output logic [5:0]  rd_waddr,
    output logic [31:0] rd_wdata,
    output logic        rd_write,
    output logic [31:0] maddr,
    output logic [31:0] mdata,
    output logic [3:0]  mstrb,
    output logic        mwrite,
    output logic        mvalid,
    output logic [31:0] retire_count,
    output logic        err_overflow
);

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_HELD  = 1'b1
    } buf_state_t;

    buf_state_t  r_mem_state, w_mem_state_nxt;
    buf_state_t  r_rd_state,  w_rd_state_nxt;

    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_data;
    logic [3:0]  r_mem_strb;
    logic        r_mem_write;
    logic [5:0]  r_rd_addr;
    logic [31:0] r_rd_data;
    logic [31:0] r_retire_count;

    logic        w_mem_cap;
    logic        w_rd_cap;
    logic [31:0] w_mem_data;
    logic [3:0]  w_mem_strb;
    logic        w_mem_overflow;
    logic        w_rd_overflow;

    // Loads are only traced when TRACE_LOADS is set; x0 writes are architecturally void.
    assign w_mem_cap      = dvalid && dready && (dwrite || TRACE_LOADS);
    assign w_rd_cap       = rf_we && !(DROP_X0 && (rf_waddr == 6'd0));
    assign w_mem_data     = dwrite ? dwdata : drdata;
    assign w_mem_strb     = dwrite ? dwstb : 4'hF;
    assign w_mem_overflow = w_mem_cap && (r_mem_state == BUF_HELD) && !i_retire;
    assign w_rd_overflow  = w_rd_cap && (r_rd_state == BUF_HELD) && !i_retire;
    assign retire_count   = r_retire_count;

    // Hold-buffer state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_mem_state <= BUF_EMPTY;
            r_rd_state  <= BUF_EMPTY;
        end else begin
            r_mem_state <= w_mem_state_nxt;
            r_rd_state  <= w_rd_state_nxt;
        end
    end

    // A retire drains both buffers (any same-cycle capture is emitted directly);
    // otherwise a capture fills the buffer.
    always_comb begin
        w_mem_state_nxt = r_mem_state;
        w_rd_state_nxt  = r_rd_state;
        if (i_retire) begin
            w_mem_state_nxt = BUF_EMPTY;
            w_rd_state_nxt  = BUF_EMPTY;
        end else begin
            if (w_mem_cap) w_mem_state_nxt = BUF_HELD;
            if (w_rd_cap)  w_rd_state_nxt  = BUF_HELD;
        end
    end

    // Buffer contents; the newest capture always wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_mem_strb  <= '0;
            r_mem_write <= 1'b0;
            r_rd_addr   <= '0;
            r_rd_data   <= '0;
        end else begin
            if (w_mem_cap) begin
                r_mem_addr  <= daddr;
                r_mem_data  <= w_mem_data;
                r_mem_strb  <= w_mem_strb;
                r_mem_write <= dwrite;
            end
            if (w_rd_cap) begin
                r_rd_addr <= rf_waddr;
                r_rd_data <= rf_wdata;
            end
        end
    end

    // Sticky overflow flag: a held event was replaced before its owner retired.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_overflow <= 1'b0;
        end else if (w_mem_overflow || w_rd_overflow) begin
            err_overflow <= 1'b1;
        end
    end

    // Aligned output event; payload fields hold between retires.
    always_ff @(posedge clock) begin
        if (reset) begin
            ivalid         <= 1'b0;
            pc             <= '0;
            instr          <= '0;
            ra_raddr       <= '0;
            rb_raddr       <= '0;
            ra_rdata       <= '0;
            rb_rdata       <= '0;
            mvalid         <= 1'b0;
            maddr          <= '0;
            mdata          <= '0;
            mstrb          <= '0;
            mwrite         <= 1'b0;
            rd_write       <= 1'b0;
            rd_waddr       <= '0;
            rd_wdata       <= '0;
            r_retire_count <= '0;
        end else begin
            ivalid   <= i_retire;
            mvalid   <= i_retire && (w_mem_cap || (r_mem_state == BUF_HELD));
            rd_write <= i_retire && (w_rd_cap || (r_rd_state == BUF_HELD));
            if (i_retire) begin
                pc             <= i_pc;
                instr          <= i_instr;
                ra_raddr       <= i_ra_raddr;
                rb_raddr       <= i_rb_raddr;
                ra_rdata       <= i_ra_rdata;
                rb_rdata       <= i_rb_rdata;
                r_retire_count <= r_retire_count + 32'd1;
                if (w_mem_cap) begin
                    maddr  <= daddr;
                    mdata  <= w_mem_data;
                    mstrb  <= w_mem_strb;
                    mwrite <= dwrite;
                end else if (r_mem_state == BUF_HELD) begin
                    maddr  <= r_mem_addr;
                    mdata  <= r_mem_data;
                    mstrb  <= r_mem_strb;
                    mwrite <= r_mem_write;
                end
                if (w_rd_cap) begin
                    rd_waddr <= rf_waddr;
                    rd_wdata <= rf_wdata;
                end else if (r_rd_state == BUF_HELD) begin
                    rd_waddr <= r_rd_addr;
                    rd_wdata <= r_rd_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_fwrisc_trace_aligner.sv
// Testbench for fwrisc_trace_aligner: a directed vector table for the main
// behaviour plus hand-written sequences for reset, parameter variants and wrap.
module tb_fwrisc_trace_aligner;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] i_pc, i_instr;
    logic        i_retire;
    logic [5:0]  i_ra_raddr, i_rb_raddr;
    logic [31:0] i_ra_rdata, i_rb_rdata;
    logic [5:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_we;
    logic        dvalid, dready, dwrite;
    logic [31:0] daddr, dwdata, drdata;
    logic [3:0]  dwstb;

    // Outputs of the default-parameter instance
    logic [31:0] pc, instr, ra_rdata, rb_rdata, rd_wdata, maddr, mdata, retire_count;
    logic [5:0]  ra_raddr, rb_raddr, rd_waddr;
    logic [3:0]  mstrb;
    logic        ivalid, rd_write, mwrite, mvalid, err_overflow;

    // Outputs of the TRACE_LOADS=1, DROP_X0=0 instance
    logic [31:0] d2_pc, d2_instr, d2_ra_rdata, d2_rb_rdata, d2_rd_wdata, d2_maddr, d2_mdata, d2_retire_count;
    logic [5:0]  d2_ra_raddr, d2_rb_raddr, d2_rd_waddr;
    logic [3:0]  d2_mstrb;
    logic        d2_ivalid, d2_rd_write, d2_mwrite, d2_mvalid, d2_err_overflow;

    fwrisc_trace_aligner dut (
        .clock(clock), .reset(reset), .i_pc(i_pc), .i_instr(i_instr), .i_retire(i_retire),
        .i_ra_raddr(i_ra_raddr), .i_rb_raddr(i_rb_raddr), .i_ra_rdata(i_ra_rdata), .i_rb_rdata(i_rb_rdata),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_we(rf_we),
        .dvalid(dvalid), .dready(dready), .dwrite(dwrite), .daddr(daddr), .dwdata(dwdata),
        .drdata(drdata), .dwstb(dwstb),
        .pc(pc), .instr(instr), .ivalid(ivalid), .ra_raddr(ra_raddr), .rb_raddr(rb_raddr),
        .ra_rdata(ra_rdata), .rb_rdata(rb_rdata), .rd_waddr(rd_waddr), .rd_wdata(rd_wdata),
        .rd_write(rd_write), .maddr(maddr), .mdata(mdata), .mstrb(mstrb), .mwrite(mwrite),
        .mvalid(mvalid), .retire_count(retire_count), .err_overflow(err_overflow)
    );

    fwrisc_trace_aligner #(.TRACE_LOADS(1'b1), .DROP_X0(1'b0)) dut2 (
        .clock(clock), .reset(reset), .i_pc(i_pc), .i_instr(i_instr), .i_retire(i_retire),
        .i_ra_raddr(i_ra_raddr), .i_rb_raddr(i_rb_raddr), .i_ra_rdata(i_ra_rdata), .i_rb_rdata(i_rb_rdata),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_we(rf_we),
        .dvalid(dvalid), .dready(dready), .dwrite(dwrite), .daddr(daddr), .dwdata(dwdata),
        .drdata(drdata), .dwstb(dwstb),
        .pc(d2_pc), .instr(d2_instr), .ivalid(d2_ivalid), .ra_raddr(d2_ra_raddr), .rb_raddr(d2_rb_raddr),
        .ra_rdata(d2_ra_rdata), .rb_rdata(d2_rb_rdata), .rd_waddr(d2_rd_waddr), .rd_wdata(d2_rd_wdata),
        .rd_write(d2_rd_write), .maddr(d2_maddr), .mdata(d2_mdata), .mstrb(d2_mstrb), .mwrite(d2_mwrite),
        .mvalid(d2_mvalid), .retire_count(d2_retire_count), .err_overflow(d2_err_overflow)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Operand fields are derived from the PC so each retire carries distinct values.
    function automatic logic [31:0] instr_of(input logic [31:0] p);
        return {p[15:0], 16'h0013};
    endfunction

    // One clock: record the PC of a live retire, then compare the aligned event.
    task automatic tick();
        logic [31:0] e;
        if (i_retire && !reset) exp_q.push_back(i_pc);
        @(posedge clock);
        #1;
        if (ivalid) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_ivalid", 32'(ivalid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", pc, e);
                check("sb_instr", instr, instr_of(e));
                check("sb_ra_raddr", 32'(ra_raddr), 32'(e[7:2]));
                check("sb_rb_raddr", 32'(rb_raddr), 32'(6'(e[7:2] + 6'd1)));
                check("sb_ra_rdata", ra_rdata, ~e);
                check("sb_rb_rdata", rb_rdata, e + 32'd1);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        i_retire = 1'b0; i_pc = '0; i_instr = '0;
        i_ra_raddr = '0; i_rb_raddr = '0; i_ra_rdata = '0; i_rb_rdata = '0;
        rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;
        dvalid = 1'b0; dready = 1'b0; dwrite = 1'b0;
        daddr = '0; dwdata = '0; drdata = '0; dwstb = '0;
    endtask

    task automatic drive_retire(input logic [31:0] p);
        i_retire = 1'b1; i_pc = p; i_instr = instr_of(p);
        i_ra_raddr = p[7:2]; i_rb_raddr = p[7:2] + 6'd1;
        i_ra_rdata = ~p; i_rb_rdata = p + 32'd1;
    endtask

    task automatic drive_rf(input logic [5:0] a, input logic [31:0] d);
        rf_we = 1'b1; rf_waddr = a; rf_wdata = d;
    endtask

    task automatic drive_bus(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        dvalid = 1'b1; dready = 1'b1; dwrite = wr;
        daddr = a; dwdata = d; drdata = d; dwstb = s;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        retire;  logic [31:0] pc;
        logic        rf_we;   logic [5:0]  waddr;   logic [31:0] wdata;
        logic        dv;      logic        dwr;     logic [31:0] daddr;  logic [31:0] ddata; logic [3:0] strb;
        logic        e_iv;    logic        e_mv;    logic        e_mw;
        logic [31:0] e_maddr; logic [31:0] e_mdata; logic [3:0]  e_mstrb;
        logic        e_rdw;   logic [5:0]  e_rda;   logic [31:0] e_rdd;
        logic [31:0] e_cnt;   logic        e_err;
    } vec_t;

    vec_t vecs[18];

    initial begin
        // fields: retire,pc | rf_we,waddr,wdata | dv,dwr,daddr,ddata,strb |
        //         e_iv,e_mv,e_mw,e_maddr,e_mdata,e_mstrb | e_rdw,e_rda,e_rdd | e_cnt,e_err
        vecs[0]  = '{0, 32'h0,  0, 6'd0, 32'h0,  0, 0, 32'h0,    32'h0,    4'h0, 0, 0, 0, 32'h0,    32'h0,    4'h0, 0, 6'd0, 32'h0,  32'd0, 0}; // idle
        vecs[1]  = '{0, 32'h0,  0, 6'd0, 32'h0,  1, 1, 32'h1000, 32'hA5A5, 4'h3, 0, 0, 0, 32'h0,    32'h0,    4'h0, 0, 6'd0, 32'h0,  32'd0, 0}; // store held
        vecs[2]  = '{0, 32'h0,  0, 6'd0, 32'h0,  0, 0, 32'h0,    32'h0,    4'h0, 0, 0, 0, 32'h0,    32'h0,    4'h0, 0, 6'd0, 32'h0,  32'd0, 0}; // still held
        vecs[3]  = '{1, 32'h80, 0, 6'd0, 32'h0,  0, 0, 32'h0,    32'h0,    4'h0, 1, 1, 1, 32'h1000, 32'hA5A5, 4'h3, 0, 6'd0, 32'h0,  32'd1, 0}; // emit store
        vecs[4]  = '{0, 32'h0,  0, 6'd0, 32'h0,  0, 0, 32'h0,    32'h0,    4'h0, 0, 0, 0, 32'h0,    32'h0,    4'h0, 0, 6'd0, 32'h0,  32'd1, 0}; // pulse drops
        vecs[5]  = '{1, 32'h84, 1, 6'd5, 32'h7,  0, 0, 32'h0,    32'h0,    4'h0, 1, 0, 0, 32'h0,    32'h0,    4'h0, 1, 6'd5, 32'h7,  32'd2, 0}; // same-cycle rd
        vecs[6]  = '{1, 32'h88, 0, 6'd0, 32'h0,  1, 0, 32'h2000, 32'h55,   4'h0, 1, 0, 0, 32'h0,    32'h0,    4'h0, 0, 6'd0, 32'h0,  32'd3, 0}; // load not traced
        vecs[7]  = '{0, 32'h0,  1, 6'd0, 32'h9,  0, 0, 32'h0,    32'h0,    4'h0, 0, 0, 0, 32'h0,    32'h0,    4'h0, 0, 6'd0, 32'h0,  32'd3, 0}; // x0 write
        vecs[8]  = '{1, 32'h8C, 0, 6'd0, 32'h0,  0, 0, 32'h0,    32'h0,    4'h0, 1, 0, 0, 32'h0,    32'h0,    4'h0, 0, 6'd0, 32'h0,  32'd4, 0}; // x0 dropped
        vecs[9]  = '{0, 32'h0,  1, 6'd3, 32'h33, 0, 0, 32'h0,    32'h0,    4'h0, 0, 0, 0, 32'h0,    32'h0,    4'h0, 0, 6'd0, 32'h0,  32'd4, 0}; // rd held
        vecs[10] = '{1, 32'h90, 1, 6'd4, 32'h44, 0, 0, 32'h0,    32'h0,    4'h0, 1, 0, 0, 32'h0,    32'h0,    4'h0, 1, 6'd4, 32'h44, 32'd5, 0}; // capture beats held
        vecs[11] = '{0, 32'h0,  0, 6'd0, 32'h0,  0, 0, 32'h0,    32'h0,    4'h0, 0, 0, 0, 32'h0,    32'h0,    4'h0, 0, 6'd0, 32'h0,  32'd5, 0}; // buffer drained
        vecs[12] = '{1, 32'h94, 0, 6'd0, 32'h0,  1, 1, 32'h3000, 32'h1,    4'hF, 1, 1, 1, 32'h3000, 32'h1,    4'hF, 0, 6'd0, 32'h0,  32'd6, 0}; // back-to-back 1
        vecs[13] = '{1, 32'h98, 1, 6'd6, 32'h66, 0, 0, 32'h0,    32'h0,    4'h0, 1, 0, 0, 32'h0,    32'h0,    4'h0, 1, 6'd6, 32'h66, 32'd7, 0}; // back-to-back 2
        vecs[14] = '{0, 32'h0,  0, 6'd0, 32'h0,  1, 1, 32'h10,   32'hAA,   4'hF, 0, 0, 0, 32'h0,    32'h0,    4'h0, 0, 6'd0, 32'h0,  32'd7, 0}; // first store
        vecs[15] = '{0, 32'h0,  0, 6'd0, 32'h0,  1, 1, 32'h20,   32'hBB,   4'h1, 0, 0, 0, 32'h0,    32'h0,    4'h0, 0, 6'd0, 32'h0,  32'd7, 1}; // overwrite
        vecs[16] = '{1, 32'h9C, 0, 6'd0, 32'h0,  0, 0, 32'h0,    32'h0,    4'h0, 1, 1, 1, 32'h20,   32'hBB,   4'h1, 0, 6'd0, 32'h0,  32'd8, 1}; // newest store
        vecs[17] = '{0, 32'h0,  0, 6'd0, 32'h0,  0, 0, 32'h0,    32'h0,    4'h0, 0, 0, 0, 32'h0,    32'h0,    4'h0, 0, 6'd0, 32'h0,  32'd8, 1}; // err sticky
    end

    // ---------------- test sequence ----------------
    initial begin
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        check("rst_ivalid", 32'(ivalid), 32'd0);
        check("rst_count", retire_count, 32'd0);
        check("rst_err", 32'(err_overflow), 32'd0);
        reset = 1'b0;

        // Table-driven main function
        for (int i = 0; i < 18; i++) begin
            clear_inputs();
            if (vecs[i].retire) drive_retire(vecs[i].pc);
            if (vecs[i].rf_we)  drive_rf(vecs[i].waddr, vecs[i].wdata);
            if (vecs[i].dv)     drive_bus(vecs[i].dwr, vecs[i].daddr, vecs[i].ddata, vecs[i].strb);
            tick();
            check($sformatf("v%0d_ivalid", i), 32'(ivalid), 32'(vecs[i].e_iv));
            check($sformatf("v%0d_mvalid", i), 32'(mvalid), 32'(vecs[i].e_mv));
            check($sformatf("v%0d_rd_write", i), 32'(rd_write), 32'(vecs[i].e_rdw));
            check($sformatf("v%0d_count", i), retire_count, vecs[i].e_cnt);
            check($sformatf("v%0d_err", i), 32'(err_overflow), 32'(vecs[i].e_err));
            if (vecs[i].e_mv) begin
                check($sformatf("v%0d_mwrite", i), 32'(mwrite), 32'(vecs[i].e_mw));
                check($sformatf("v%0d_maddr", i), maddr, vecs[i].e_maddr);
                check($sformatf("v%0d_mdata", i), mdata, vecs[i].e_mdata);
                check($sformatf("v%0d_mstrb", i), 32'(mstrb), 32'(vecs[i].e_mstrb));
            end
            if (vecs[i].e_rdw) begin
                check($sformatf("v%0d_rd_waddr", i), 32'(rd_waddr), 32'(vecs[i].e_rda));
                check($sformatf("v%0d_rd_wdata", i), rd_wdata, vecs[i].e_rdd);
            end
        end

        // Reset mid-operation: held store and in-reset events are discarded
        clear_inputs();
        drive_bus(1'b1, 32'h40, 32'hCC, 4'hF);
        tick();
        reset = 1'b1;
        drive_retire(32'hA4);
        drive_rf(6'd9, 32'h99);
        tick();
        check("inrst_ivalid", 32'(ivalid), 32'd0);
        check("inrst_mvalid", 32'(mvalid), 32'd0);
        check("inrst_rd_write", 32'(rd_write), 32'd0);
        check("inrst_pc", pc, 32'd0);
        check("inrst_maddr", maddr, 32'd0);
        check("inrst_count", retire_count, 32'd0);
        check("inrst_err", 32'(err_overflow), 32'd0);
        reset = 1'b0;
        clear_inputs();
        drive_retire(32'hA0);
        tick();
        check("postrst_ivalid", 32'(ivalid), 32'd1);
        check("postrst_mvalid", 32'(mvalid), 32'd0);
        check("postrst_rd_write", 32'(rd_write), 32'd0);
        check("postrst_count", retire_count, 32'd1);

        // x0 write: filtered by default instance, kept by DROP_X0=0 instance
        clear_inputs();
        drive_retire(32'hA8);
        drive_rf(6'd0, 32'h12);
        tick();
        check("x0_drop_rd_write", 32'(rd_write), 32'd0);
        check("x0_keep_rd_write", 32'(d2_rd_write), 32'd1);
        check("x0_keep_rd_waddr", 32'(d2_rd_waddr), 32'd0);
        check("x0_keep_rd_wdata", d2_rd_wdata, 32'h12);

        // Load: traced only with TRACE_LOADS=1, full strobe, mwrite=0
        clear_inputs();
        drive_retire(32'hAC);
        drive_bus(1'b0, 32'h50, 32'h77, 4'h2);
        tick();
        check("load_off_mvalid", 32'(mvalid), 32'd0);
        check("load_on_mvalid", 32'(d2_mvalid), 32'd1);
        check("load_on_mwrite", 32'(d2_mwrite), 32'd0);
        check("load_on_maddr", d2_maddr, 32'h50);
        check("load_on_mdata", d2_mdata, 32'h77);
        check("load_on_mstrb", 32'(d2_mstrb), 32'hF);

        // dvalid without dready is not a transfer
        clear_inputs();
        drive_bus(1'b1, 32'h60, 32'h5, 4'hF);
        dready = 1'b0;
        tick();
        clear_inputs();
        drive_retire(32'hB0);
        tick();
        check("nohs_ivalid", 32'(ivalid), 32'd1);
        check("nohs_mvalid", 32'(mvalid), 32'd0);
        check("nohs_count", retire_count, 32'd4);

        // Counter wrap from all-ones to zero
        clear_inputs();
        @(negedge clock);
        force dut.r_retire_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_retire_count;
        drive_retire(32'hB4);
        tick();
        check("wrap_ivalid", 32'(ivalid), 32'd1);
        check("wrap_count", retire_count, 32'd0);
        clear_inputs();
        tick();
        check("wrap_idle_ivalid", 32'(ivalid), 32'd0);

        check("sb_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time bound so the run always terminates
    initial begin
        #100000;
        $display("FAIL timeout: got %0d checks expected completion", n_checks);
        $fatal(1);
    end

endmodule
